dual_da_rom_scheduler: RTL and testbench

- Time-multiplexed scheduler that shares one 1024x10b distributed waveform ROM between two DA channels in the high-speed dual-DA design.
- Keeps one phase accumulator per channel and issues one ROM address per cycle, alternating channel 0 and channel 1.
- Routes returned ROM words to per-channel sample registers with valid strobes.
- Accepts per-channel frequency, phase-offset and enable updates through a valid/ready config port. Updates apply at a channel-slot boundary.

---
 rtl/dual_da_rom_scheduler_if.sv | 23 ++
 rtl/dual_da_rom_scheduler.sv | 112 +++++++++++
 tb/tb_dual_da_rom_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dual_da_rom_scheduler_if.sv
// Configuration port of the dual-channel DA ROM scheduler: per-channel
// frequency, phase-offset and enable updates over a valid/ready handshake.
interface dual_da_rom_scheduler_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int ACC_WIDTH  = 32
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  cfg_ch;
    logic [ACC_WIDTH-1:0]  cfg_fword;
    logic [ADDR_WIDTH-1:0] cfg_poff;
    logic                  cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_fword, cfg_poff, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_fword, cfg_poff, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/dual_da_rom_scheduler.sv
// Shares one waveform ROM between two DA channels: alternating-slot phase
// accumulators issue addresses, a tag pipeline routes returned words per channel.
module dual_da_rom_scheduler #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 10,
    parameter int ACC_WIDTH   = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_da_rom_scheduler_if.slave cfg,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] da0_data,
    output logic                  da0_valid,
    output logic [DATA_WIDTH-1:0] da1_data,
    output logic                  da1_valid
);
    logic                  slot;
    logic [ACC_WIDTH-1:0]  acc   [2];
    logic [ACC_WIDTH-1:0]  fword [2];
    logic [ADDR_WIDTH-1:0] poff  [2];
    logic                  en    [2];

    logic                  pending;
    logic                  shadow_ch;
    logic                  shadow_en;
    logic [ACC_WIDTH-1:0]  shadow_fword;
    logic [ADDR_WIDTH-1:0] shadow_poff;

    // Tag bit i belongs to stage _p<i>; the MSB is the stage whose ROM word is ready.
    logic [ROM_LATENCY:0]  tag_vld_p;
    logic [ROM_LATENCY:0]  tag_ch_p;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  access_en;
    logic                  cfg_fire;
    logic                  cfg_apply;
    logic                  cap0;
    logic                  cap1;

    assign cfg.cfg_ready = ~pending;

    always_comb begin
        access_en = en[slot];
        next_addr = acc[slot][ACC_WIDTH-1 -: ADDR_WIDTH] + poff[slot];
        cfg_fire  = cfg.cfg_valid & ~pending;
        cfg_apply = pending & (slot == shadow_ch);
        cap0      = tag_vld_p[ROM_LATENCY] & ~tag_ch_p[ROM_LATENCY];
        cap1      = tag_vld_p[ROM_LATENCY] &  tag_ch_p[ROM_LATENCY];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot         <= 1'b0;
            acc[0]       <= '0;
            acc[1]       <= '0;
            fword[0]     <= '0;
            fword[1]     <= '0;
            poff[0]      <= '0;
            poff[1]      <= '0;
            en[0]        <= 1'b0;
            en[1]        <= 1'b0;
            pending      <= 1'b0;
            shadow_ch    <= 1'b0;
            shadow_en    <= 1'b0;
            shadow_fword <= '0;
            shadow_poff  <= '0;
            tag_vld_p    <= '0;
            tag_ch_p     <= '0;
            rom_addr     <= '0;
            da0_data     <= '0;
            da0_valid    <= 1'b0;
            da1_data     <= '0;
            da1_valid    <= 1'b0;
        end else begin
            slot <= ~slot;

            // Access stage (_p0): address out, accumulator step, tag launch
            tag_vld_p <= (tag_vld_p << 1) | (ROM_LATENCY+1)'(access_en);
            tag_ch_p  <= (tag_ch_p  << 1) | (ROM_LATENCY+1)'(slot);
            if (access_en) begin
                rom_addr  <= next_addr;
                acc[slot] <= acc[slot] + fword[slot];
            end

            // The apply edge's own access above still uses the old settings.
            if (cfg_fire) begin
                shadow_ch    <= cfg.cfg_ch;
                shadow_en    <= cfg.cfg_en;
                shadow_fword <= cfg.cfg_fword;
                shadow_poff  <= cfg.cfg_poff;
                pending      <= 1'b1;
            end else if (cfg_apply) begin
                fword[shadow_ch] <= shadow_fword;
                poff[shadow_ch]  <= shadow_poff;
                en[shadow_ch]    <= shadow_en;
                if (shadow_en && !en[shadow_ch])
                    acc[shadow_ch] <= '0;
                pending          <= 1'b0;
            end

            // Capture stage (_p<ROM_LATENCY>): route the returned word
            da0_valid <= cap0;
            da1_valid <= cap1;
            if (cap0)
                da0_data <= rom_data;
            if (cap1)
                da1_data <= rom_data;
        end
    end
endmodule

// File: tb/tb_dual_da_rom_scheduler.sv
// Bench for dual_da_rom_scheduler: directed and random config traffic checked
// against a transaction-level model (per-channel phase, fetch queue with due cycles).
module tb_dual_da_rom_scheduler;
    localparam int ADDR_WIDTH  = 10;
    localparam int DATA_WIDTH  = 10;
    localparam int ACC_WIDTH   = 32;
    localparam int ROM_LATENCY = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] da0_data;
    logic                  da0_valid;
    logic [DATA_WIDTH-1:0] da1_data;
    logic                  da1_valid;

    dual_da_rom_scheduler_if #(.ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) cfg_if ();

    dual_da_rom_scheduler #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .ROM_LATENCY(ROM_LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg_if),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .da0_data (da0_data),
        .da0_valid(da0_valid),
        .da1_data (da1_data),
        .da1_valid(da1_valid)
    );

    always #5 clk = ~clk;

    // Registered ROM (one cycle of read latency)
    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
    always @(posedge clk) rom_data <= mem[rom_addr];

    // Reference model state
    typedef struct {
        int unsigned           due;
        bit                    ch;
        bit [ADDR_WIDTH-1:0]   addr;
    } fetch_t;

    fetch_t              inflight[$];
    int unsigned         cyc;
    bit [ACC_WIDTH-1:0]  m_acc   [2];
    bit [ACC_WIDTH-1:0]  m_fword [2];
    bit [ADDR_WIDTH-1:0] m_poff  [2];
    bit                  m_en    [2];
    bit                  m_pending;
    bit                  sh_ch;
    bit                  sh_en;
    bit [ACC_WIDTH-1:0]  sh_fword;
    bit [ADDR_WIDTH-1:0] sh_poff;
    bit [ADDR_WIDTH-1:0] exp_addr;
    bit [DATA_WIDTH-1:0] exp_data  [2];
    bit                  exp_valid [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic bit [ADDR_WIDTH-1:0] phase_addr(bit [ACC_WIDTH-1:0] phase,
                                                       bit [ADDR_WIDTH-1:0] offset);
        return ADDR_WIDTH'((phase >> (ACC_WIDTH - ADDR_WIDTH)) + ACC_WIDTH'(offset));
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        cyc       = 0;
        m_pending = 0;
        sh_ch     = 0;
        sh_en     = 0;
        sh_fword  = '0;
        sh_poff   = '0;
        exp_addr  = '0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k]     = '0;
            m_fword[k]   = '0;
            m_poff[k]    = '0;
            m_en[k]      = 0;
            exp_data[k]  = '0;
            exp_valid[k] = 0;
        end
    endtask

    // One clock of the model, using the inputs present before the edge.
    task automatic model_step(output bit accepted);
        bit     ch;
        fetch_t f;
        ch = cyc[0];
        exp_valid[0] = 0;
        exp_valid[1] = 0;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            f = inflight.pop_front();
            exp_valid[f.ch] = 1;
            exp_data[f.ch]  = mem[f.addr];
        end
        if (m_en[ch]) begin
            exp_addr = phase_addr(m_acc[ch], m_poff[ch]);
            f.due  = cyc + 1 + ROM_LATENCY;
            f.ch   = ch;
            f.addr = exp_addr;
            inflight.push_back(f);
            m_acc[ch] = m_acc[ch] + m_fword[ch];
        end
        accepted = 0;
        if (cfg_if.cfg_valid && !m_pending) begin
            sh_ch     = cfg_if.cfg_ch;
            sh_en     = cfg_if.cfg_en;
            sh_fword  = cfg_if.cfg_fword;
            sh_poff   = cfg_if.cfg_poff;
            m_pending = 1;
            accepted  = 1;
        end else if (m_pending && sh_ch == ch) begin
            if (sh_en && !m_en[ch])
                m_acc[ch] = '0;
            m_en[ch]    = sh_en;
            m_fword[ch] = sh_fword;
            m_poff[ch]  = sh_poff;
            m_pending   = 0;
        end
        cyc++;
    endtask

    task automatic cycle(output bit accepted);
        accepted = 0;
        if (rst)
            model_reset();
        else
            model_step(accepted);
        @(posedge clk);
        #1;
        check("rom_addr",  64'(rom_addr),         64'(exp_addr));
        check("da0_valid", 64'(da0_valid),        64'(exp_valid[0]));
        check("da0_data",  64'(da0_data),         64'(exp_data[0]));
        check("da1_valid", 64'(da1_valid),        64'(exp_valid[1]));
        check("da1_data",  64'(da1_data),         64'(exp_data[1]));
        check("cfg_ready", 64'(cfg_if.cfg_ready), 64'(!m_pending));
    endtask

    task automatic run(int n);
        bit acc_unused;
        for (int i = 0; i < n; i++)
            cycle(acc_unused);
    endtask

    // Holds the request until the handshake completes, bounded in cycles.
    task automatic send_cfg(bit ch, bit [ACC_WIDTH-1:0] fw, bit [ADDR_WIDTH-1:0] po, bit en);
        bit accepted;
        accepted         = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_fword = fw;
        cfg_if.cfg_poff  = po;
        cfg_if.cfg_en    = en;
        for (int i = 0; i < 8 && !accepted; i++)
            cycle(accepted);
        check("cfg_accept", 64'(accepted), 64'(1));
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++)
            mem[i] = DATA_WIDTH'($urandom_range(0, (1 << DATA_WIDTH) - 1));
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 1'b0;
        cfg_if.cfg_fword = '0;
        cfg_if.cfg_poff  = '0;
        cfg_if.cfg_en    = 1'b0;

        rst = 1'b1;
        run(2);
        rst = 1'b0;

        // Single channel, unit step
        send_cfg(0, 32'h0040_0000, 10'h000, 1);
        run(16);

        // Second channel with double step and offset
        send_cfg(1, 32'h0080_0000, 10'h100, 1);
        run(16);

        // Address wrap through the offset, then half-turn step
        send_cfg(0, 32'h0040_0000, 10'h3FF, 1);
        run(10);
        send_cfg(0, 32'h8000_0000, 10'h000, 1);
        run(10);

        // Phase-continuous retune, with a second request held while pending
        send_cfg(0, 32'h0040_0000, 10'h000, 1);
        run(6);
        send_cfg(0, 32'h0080_0000, 10'h000, 1);
        send_cfg(1, 32'h0080_0000, 10'h100, 1);
        run(10);

        // Disable then re-enable channel 1
        send_cfg(1, 32'h0080_0000, 10'h100, 0);
        run(12);
        send_cfg(1, 32'h0080_0000, 10'h100, 1);
        run(12);

        // Random reconfiguration traffic
        for (int r = 0; r < 40; r++) begin
            send_cfg(1'($urandom_range(0, 1)), $urandom, ADDR_WIDTH'($urandom),
                     $urandom_range(0, 3) != 0);
            run($urandom_range(0, 12));
        end

        // Reset with samples in flight
        send_cfg(0, 32'h0040_0000, 10'h010, 1);
        send_cfg(1, 32'h00C0_0000, 10'h020, 1);
        run(9);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
